mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand width; the HI/LO result is 2*WIDTH bits; legal values 8..64 and even.
REQ-002 Parameter CNT_W, default 6: iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  request; sampled only in IDLE.
- annul_i  in  1  cancel the in-flight operation.
- op_i  in  3  MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU.
- opdata1_i  in  WIDTH  multiplicand or dividend.
- opdata2_i  in  WIDTH  multiplier or divisor.
- hilo_i  in  2*WIDTH  current {HI,LO}, used by MADD/MSUB.
- busy_o  out  1  operation in flight; drives the execute-stage stall request.
- done_o  out  1  result valid, one-cycle pulse.
- hi_o  out  WIDTH  result high half or remainder.
- lo_o  out  WIDTH  result low half or quotient.
- divzero_o  out  1  divisor was zero; valid with done_o.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-005 IDLE transitions:
- start_i=1 and annul_i=0: latch op_i, the operands, and hilo_i (MADD/MSUB only); go to BUSY with counter=0.
- DIV/DIVU with opdata2_i=0: go directly to DONE.
REQ-006 BUSY SHALL perform one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-007 BUSY SHALL go to DONE after exactly WIDTH iterations.
REQ-008 Latency: with acceptance in cycle 0, done_o SHALL be high in cycle WIDTH+1. For divide-by-zero it SHALL be high in cycle 1.
REQ-009 DONE SHALL hold for one cycle, asserting done_o with the final hi_o/lo_o, then return to IDLE.
REQ-010 A new start_i SHALL be accepted no earlier than the cycle after DONE.
REQ-011 busy_o SHALL be 1 in BUSY and 0 in IDLE and DONE.
REQ-012 start_i outside IDLE SHALL be ignored. Operand or op changes after acceptance SHALL have no effect.
REQ-013 Signed ops (MULT, MADD, MSUB, DIV):
- Operate on magnitudes.
- The product is negated when the operand MSBs differ.
- The quotient is negated when the operand MSBs differ.
- The remainder takes the sign of the dividend.
REQ-014 Unsigned ops SHALL treat operands as plain binary.
REQ-015 MADD/MADDU result SHALL be latched hilo + product, modulo 2^(2*WIDTH).
REQ-016 MSUB/MSUBU result SHALL be latched hilo - product, modulo 2^(2*WIDTH).
REQ-017 MULT/MULTU result SHALL be {hi_o,lo_o} = the full 2*WIDTH product.
REQ-018 DIV/DIVU result SHALL be lo_o = quotient and hi_o = remainder.
REQ-019 Signed overflow (most-negative / -1) SHALL return lo_o = most-negative value and hi_o = 0.
REQ-020 Divide-by-zero SHALL return lo_o = all ones, hi_o = dividend, divzero_o = 1.
REQ-021 annul_i=1 in BUSY or DONE SHALL force IDLE on the next edge and suppress done_o in that cycle; annul_i has priority over start_i.
REQ-022 hi_o and lo_o SHALL hold the last result until the next DONE and are undefined-free (registered). divzero_o SHALL be 0 except in DONE.

Reset
REQ-023 While rst=1 at a rising edge: state=IDLE, counter=0, busy_o=0, done_o=0, divzero_o=0, hi_o=0, lo_o=0, all datapath registers=0.
REQ-024 Reset SHALL take priority over start_i and annul_i and SHALL abort any in-flight operation without asserting done_o.

Structure
REQ-025 The op_i encodings, the FSM state encodings, and the default WIDTH SHALL live in the shared defines package used by the execute stage.
REQ-026 The iteration datapath SHALL be one sub-module, mdu_iter_core, containing the accumulator, shift register, and per-cycle add/subtract.
REQ-027 mdu_iter SHALL keep the FSM, sign handling, and accumulate.

Verification (WIDTH=32)
REQ-028 MULT -3 x 5: done_o in cycle 33; hi_o=FFFFFFFF, lo_o=FFFFFFF1.
REQ-029 DIV -7 / 2: lo_o=FFFFFFFD, hi_o=FFFFFFFF, divzero_o=0.
REQ-030 DIVU 0x1234 / 0: done_o in cycle 1; lo_o=FFFFFFFF, hi_o=00001234, divzero_o=1.
REQ-031 MADDU with hilo_i=00000001_FFFFFFFF, operands 1 x 1: {hi_o,lo_o}=00000002_00000000. MSUB with hilo_i=0, operands 2 x 3: FFFFFFFF_FFFFFFFA.
REQ-032 Abort and restart:
- DIVU 100/7, annul_i in cycle 10: IDLE in cycle 11, no done_o pulse.
- Then start MULTU 6 x 7: done_o 33 cycles later with lo_o=0000002A.
REQ-033 Busy-time events:
- start_i held high during BUSY: exactly one done_o per accepted op.
- rst asserted in cycle 5 of an op: all outputs 0 next cycle, no done_o.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, defaults.
package mdu_iter_pkg;

   localparam int unsigned DefaultWidth = 32;
   localparam int unsigned DefaultCntW  = 6;

   typedef enum logic [2:0] {
      OpMult  = 3'd0,
      OpMultu = 3'd1,
      OpMadd  = 3'd2,
      OpMaddu = 3'd3,
      OpMsub  = 3'd4,
      OpMsubu = 3'd5,
      OpDiv   = 3'd6,
      OpDivu  = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } mdu_state_e;

   function automatic logic op_is_signed(input mdu_op_e op);
      return (op == OpMult) || (op == OpMadd) || (op == OpMsub) || (op == OpDiv);
   endfunction

   function automatic logic op_is_div(input mdu_op_e op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

   function automatic logic op_is_acc(input mdu_op_e op);
      return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
   endfunction

   function automatic logic op_is_sub(input mdu_op_e op);
      return (op == OpMsub) || (op == OpMsubu);
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the execute stage and the iterative MDU.
interface mdu_iter_if import mdu_iter_pkg::*; #(
   parameter int unsigned WIDTH = DefaultWidth
);
   logic               start_i;
   logic               annul_i;
   logic [2:0]         op_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic [2*WIDTH-1:0] hilo_i;
   logic               busy_o;
   logic               done_o;
   logic [WIDTH-1:0]   hi_o;
   logic [WIDTH-1:0]   lo_o;
   logic               divzero_o;

   modport slave (
      input  start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
      output busy_o, done_o, hi_o, lo_o, divzero_o
   );

   modport master (
      output start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
      input  busy_o, done_o, hi_o, lo_o, divzero_o
   );
endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply and restoring divide on unsigned magnitudes.
module mdu_iter_core import mdu_iter_pkg::*; #(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] shift_i,
   input  logic [WIDTH-1:0] hold_i,
   output logic [WIDTH-1:0] acc_nxt_o,
   output logic [WIDTH-1:0] sh_nxt_o
);
   logic [WIDTH-1:0] acc_q, sh_q, hold_q;
   logic             div_q;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;

   // Multiply: {acc,sh} is the product register. Divide: acc is remainder, sh is quotient.
   always_comb begin
      sum    = {1'b0, acc_q} + {1'b0, hold_q};
      rem_sh = {acc_q, sh_q[WIDTH-1]};
      rem_ge = rem_sh >= {1'b0, hold_q};
      if (div_q) begin
         acc_nxt_o = rem_ge ? WIDTH'(rem_sh - {1'b0, hold_q}) : rem_sh[WIDTH-1:0];
         sh_nxt_o  = {sh_q[WIDTH-2:0], rem_ge};
      end else if (sh_q[0]) begin
         acc_nxt_o = sum[WIDTH:1];
         sh_nxt_o  = {sum[0], sh_q[WIDTH-1:1]};
      end else begin
         acc_nxt_o = {1'b0, acc_q[WIDTH-1:1]};
         sh_nxt_o  = {acc_q[0], sh_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         sh_q   <= '0;
         hold_q <= '0;
         div_q  <= 1'b0;
      end else if (load_i) begin
         acc_q  <= '0;
         sh_q   <= shift_i;
         hold_q <= hold_i;
         div_q  <= div_i;
      end else if (step_i) begin
         acc_q  <= acc_nxt_o;
         sh_q   <= sh_nxt_o;
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: FSM, sign handling and HI/LO accumulate around mdu_iter_core.
module mdu_iter import mdu_iter_pkg::*; #(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned CNT_W = DefaultCntW
) (
   input logic       clk,
   input logic       rst,
   mdu_iter_if.slave bus
);
   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   mdu_op_e            op_q, op_d;
   logic [2*WIDTH-1:0] hilo_q, hilo_d;
   logic               neg_q, neg_d, rem_neg_q, rem_neg_d;
   logic               divzero_q, divzero_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   mdu_op_e            op_in;
   logic               in_signed, in_div, div_zero, accept;
   logic [WIDTH-1:0]   mag1, mag2, acc_nxt, sh_nxt, quo, rem;
   logic [2*WIDTH-1:0] prod_mag, prod, mac;

   always_comb begin
      op_in     = mdu_op_e'(bus.op_i);
      in_signed = op_is_signed(op_in);
      in_div    = op_is_div(op_in);
      mag1      = (in_signed && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
      mag2      = (in_signed && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
      div_zero  = in_div && (bus.opdata2_i == '0);
      accept    = (state_q == StIdle) && bus.start_i && !bus.annul_i;
   end

   mdu_iter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept && !div_zero),
      .step_i    (state_q == StBusy),
      .div_i     (in_div),
      .shift_i   (in_div ? mag1 : mag2),
      .hold_i    (in_div ? mag2 : mag1),
      .acc_nxt_o (acc_nxt),
      .sh_nxt_o  (sh_nxt)
   );

   // Final results are formed from the core's last-step value so they register on DONE entry.
   always_comb begin
      prod_mag = {acc_nxt, sh_nxt};
      prod     = neg_q ? -prod_mag : prod_mag;
      mac      = op_is_sub(op_q) ? hilo_q - prod : hilo_q + prod;
      quo      = neg_q ? -sh_nxt : sh_nxt;
      rem      = rem_neg_q ? -acc_nxt : acc_nxt;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      hilo_d    = hilo_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      divzero_d = divzero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         StIdle: begin
            divzero_d = 1'b0;
            if (accept) begin
               op_d      = op_in;
               cnt_d     = '0;
               neg_d     = in_signed && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
               rem_neg_d = in_signed && bus.opdata1_i[WIDTH-1];
               hilo_d    = op_is_acc(op_in) ? bus.hilo_i : '0;
               if (div_zero) begin
                  state_d   = StDone;
                  divzero_d = 1'b1;
                  hi_d      = bus.opdata1_i;
                  lo_d      = '1;
               end else begin
                  state_d   = StBusy;
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StDone;
               cnt_d   = '0;
               if (op_is_div(op_q)) begin
                  hi_d = rem;
                  lo_d = quo;
               end else begin
                  {hi_d, lo_d} = mac;
               end
            end
         end
         StDone: begin
            state_d   = StIdle;
            divzero_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
      if (bus.annul_i && (state_q != StIdle)) begin
         state_d   = StIdle;
         cnt_d     = '0;
         divzero_d = 1'b0;
         hi_d      = hi_q;
         lo_d      = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= OpMult;
         hilo_q    <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         divzero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         hilo_q    <= hilo_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         divzero_q <= divzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.busy_o    = (state_q == StBusy);
   assign bus.done_o    = (state_q == StDone) && !bus.annul_i;
   assign bus.divzero_o = (state_q == StDone) && !bus.annul_i && divzero_q;
   assign bus.hi_o      = hi_q;
   assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against a plain-arithmetic reference model.
module tb_mdu_iter;
   import mdu_iter_pkg::*;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mdu_iter_if #(.WIDTH(W)) bus ();

   mdu_iter #(
      .WIDTH(W),
      .CNT_W(6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic         dz;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic res_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [63:0] hilo);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     p;
      res_t            res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      p   = '0;
      res = '0;
      case (mdu_op_e'(op))
         OpMult:  p = sa * sb;
         OpMultu: p = ua * ub;
         OpMadd:  p = hilo + sa * sb;
         OpMaddu: p = hilo + ua * ub;
         OpMsub:  p = hilo - sa * sb;
         OpMsubu: p = hilo - ua * ub;
         OpDiv: begin
            if (b == '0) begin
               q = '1;
               r = sa;
            end else begin
               q = sa / sb;
               r = sa % sb;
            end
            p = {r[31:0], q[31:0]};
         end
         default: begin
            if (b == '0) p = {a, 32'hFFFF_FFFF};
            else         p = {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
      res.dz = (op[2:1] == 2'b11) && (b == '0);
      res.hi = p[63:32];
      res.lo = p[31:0];
      return res;
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issues one op, scrambles inputs after acceptance and checks busy/done every cycle.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] hilo, input bit hold, input string tag);
      res_t e;
      int   exp_lat;
      e       = ref_model(op, a, b, hilo);
      exp_lat = e.dz ? 1 : W + 1;
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = op;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      bus.hilo_i    = hilo;
      for (int lat = 1; lat <= exp_lat; lat++) begin
         @(posedge clk);
         #1;
         if (!hold) bus.start_i = 1'b0;
         bus.op_i      = 3'($urandom_range(0, 7));
         bus.opdata1_i = $urandom;
         bus.opdata2_i = $urandom;
         bus.hilo_i    = {$urandom, $urandom};
         @(negedge clk);
         check_eq({tag, ".busy"}, 64'(bus.busy_o), 64'(lat < exp_lat));
         check_eq({tag, ".done"}, 64'(bus.done_o), 64'(lat == exp_lat));
      end
      check_eq({tag, ".hi"}, 64'(bus.hi_o), 64'(e.hi));
      check_eq({tag, ".lo"}, 64'(bus.lo_o), 64'(e.lo));
      check_eq({tag, ".divzero"}, 64'(bus.divzero_o), 64'(e.dz));
      bus.start_i = 1'b0;
      @(negedge clk);
      check_eq({tag, ".done_once"}, 64'(bus.done_o), 64'd0);
      check_eq({tag, ".idle_busy"}, 64'(bus.busy_o), 64'd0);
      check_eq({tag, ".hold_lo"}, 64'(bus.lo_o), 64'(e.lo));
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done_o) seen = 1'b1;
      end
      check_eq({tag, ".no_done"}, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [W-1:0] lo_prev;
      rst           = 1'b1;
      bus.start_i   = 1'b0;
      bus.annul_i   = 1'b0;
      bus.op_i      = '0;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;
      bus.hilo_i    = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst.busy", 64'(bus.busy_o), 64'd0);
      check_eq("rst.done", 64'(bus.done_o), 64'd0);
      check_eq("rst.divzero", 64'(bus.divzero_o), 64'd0);
      check_eq("rst.hi", 64'(bus.hi_o), 64'd0);
      check_eq("rst.lo", 64'(bus.lo_o), 64'd0);

      // Directed cases.
      run_op(OpMult, -32'sd3, 32'd5, 64'd0, 1'b0, "mult_m3x5");
      run_op(OpDiv, -32'sd7, 32'd2, 64'd0, 1'b0, "div_m7d2");
      run_op(OpDivu, 32'h1234, 32'd0, 64'd0, 1'b0, "divu_zero");
      run_op(OpMaddu, 32'd1, 32'd1, 64'h1_FFFF_FFFF, 1'b0, "maddu_carry");
      run_op(OpMsub, 32'd2, 32'd3, 64'd0, 1'b0, "msub_2x3");
      run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1'b1, "div_ovf");
      run_op(OpMult, 32'h8000_0000, 32'h8000_0000, 64'd0, 1'b1, "mult_minmin");
      check_eq("mult_minmin.hi_exact", 64'(bus.hi_o), 64'h4000_0000);

      // annul has priority over start in IDLE.
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.annul_i = 1'b1;
      bus.op_i    = OpMultu;
      @(negedge clk);
      check_eq("annul_idle.busy", 64'(bus.busy_o), 64'd0);
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;

      // Abort DIVU 100/7 in cycle 10, then restart.
      lo_prev = bus.lo_o;
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = OpDivu;
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1 bus.annul_i = 1'b1;
      @(negedge clk);
      check_eq("annul_busy.done", 64'(bus.done_o), 64'd0);
      @(posedge clk);
      #1 bus.annul_i = 1'b0;
      @(negedge clk);
      check_eq("annul_busy.idle", 64'(bus.busy_o), 64'd0);
      watch_no_done("annul_busy", 40);
      check_eq("annul_busy.lo_kept", 64'(bus.lo_o), 64'(lo_prev));
      run_op(OpMultu, 32'd6, 32'd7, 64'd0, 1'b0, "multu_6x7");
      check_eq("multu_6x7.lo_exact", 64'(bus.lo_o), 64'h2A);

      // annul in DONE suppresses the pulse.
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = OpDivu;
      bus.opdata1_i = 32'd5;
      bus.opdata2_i = 32'd0;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      @(negedge clk);
      check_eq("annul_done.pre", 64'(bus.done_o), 64'd1);
      bus.annul_i = 1'b1;
      #1;
      check_eq("annul_done.done", 64'(bus.done_o), 64'd0);
      check_eq("annul_done.divzero", 64'(bus.divzero_o), 64'd0);
      @(posedge clk);
      #1 bus.annul_i = 1'b0;
      @(negedge clk);
      check_eq("annul_done.after", 64'(bus.done_o), 64'd0);

      // Reset in cycle 5 of a multiply.
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.op_i      = OpMult;
      bus.opdata1_i = 32'd9;
      bus.opdata2_i = 32'd9;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("midrst.busy", 64'(bus.busy_o), 64'd0);
      check_eq("midrst.done", 64'(bus.done_o), 64'd0);
      check_eq("midrst.divzero", 64'(bus.divzero_o), 64'd0);
      check_eq("midrst.hi", 64'(bus.hi_o), 64'd0);
      check_eq("midrst.lo", 64'(bus.lo_o), 64'd0);
      watch_no_done("midrst", 40);

      // Randomized ops across all op codes.
      for (int i = 0; i < 48; i++) begin
         logic [W-1:0] a, b;
         a = pick_operand();
         b = pick_operand();
         run_op(3'($urandom_range(0, 7)), a, b, {$urandom, $urandom}, 1'($urandom),
                $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
